// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Operation codes follow the M-extension funct3 encoding.
package muldiv_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Which operand is interpreted as two's complement for a given op.
  function automatic logic op_signed_a(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_b(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Controller <-> multiply/divide unit request/response bundle.
// Handshake: the master raises mm_start with stable mm_op/mm_a/mm_b and holds it until it
// sees mm_done (a one-cycle pulse, mm_result valid only then); dropping mm_start early aborts.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic                  mm_start;
  logic [2:0]            mm_op;
  logic [DATA_WIDTH-1:0] mm_a;
  logic [DATA_WIDTH-1:0] mm_b;
  logic                  mm_done;
  logic [DATA_WIDTH-1:0] mm_result;
  logic                  mm_busy;

  modport master (
    output mm_start, mm_op, mm_a, mm_b,
    input  mm_done, mm_result, mm_busy
  );

  modport slave (
    input  mm_start, mm_op, mm_a, mm_b,
    output mm_done, mm_result, mm_busy
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: a shift-add multiply step (LSB-first)
// or a restoring divide step (MSB-first). Purely combinational.
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH:0]   hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] opnd,
  output logic [DATA_WIDTH:0]   hi_next,
  output logic [DATA_WIDTH-1:0] lo_next
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  // Multiply: hi = partial product upper half, lo = remaining multiplier bits.
  // Divide:   hi = partial remainder,         lo = dividend bits / quotient bits.
  always_comb begin
    sum     = hi + {1'b0, (lo[0] ? opnd : {DATA_WIDTH{1'b0}})};
    shifted = {hi[DATA_WIDTH-1:0], lo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_next = {1'b0, sum[DATA_WIDTH:1]};
    lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
    if (is_div) begin
      // A set top bit of diff means the trial subtract borrowed: restore.
      if (diff[DATA_WIDTH]) begin
        hi_next = shifted;
        lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
      end else begin
        hi_next = diff;
        lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign conditioning, IDLE/BUSY/DONE control,
// special-case divides and final sign fix around a single muldiv_step datapath.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus,
  output md_state_e    dbg_state
);

  localparam int W = DATA_WIDTH;

  md_state_e            state_q, state_d;
  md_op_e               op_q, op_in;
  logic                 neg_q, neg_rem_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W:0]           hi_q, hi_step;
  logic [W-1:0]         lo_q, lo_step, opnd_q;
  logic                 sa, sb, is_div_in, div_zero, div_ovf;
  logic [W-1:0]         mag_a, mag_b;
  logic [2*W-1:0]       prod, prod_fix;
  logic [W-1:0]         quo_fix, rem_fix, result_sel;

  assign op_in     = md_op_e'(bus.mm_op);
  assign sa        = op_signed_a(op_in) & bus.mm_a[W-1];
  assign sb        = op_signed_b(op_in) & bus.mm_b[W-1];
  assign mag_a     = sa ? -bus.mm_a : bus.mm_a;
  assign mag_b     = sb ? -bus.mm_b : bus.mm_b;
  assign is_div_in = op_in[2];
  assign div_zero  = is_div_in && (bus.mm_b == '0);
  assign div_ovf   = (op_in inside {MD_DIV, MD_REM}) &&
                     (bus.mm_a == {1'b1, {(W-1){1'b0}}}) && (bus.mm_b == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (bus.mm_start) state_d = (div_zero || div_ovf) ? MD_DONE : MD_BUSY;
      MD_BUSY: begin
        if (!bus.mm_start)                          state_d = MD_IDLE;
        else if (cnt_q == CNT_WIDTH'(W - 1))        state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  muldiv_step #(.DATA_WIDTH(W)) u_step (
    .is_div  (op_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  // Special cases preload the final quotient/remainder with the sign fix disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: if (bus.mm_start) begin
          op_q      <= op_in;
          cnt_q     <= '0;
          opnd_q    <= is_div_in ? mag_b : mag_a;
          if (div_zero) begin
            hi_q      <= {1'b0, bus.mm_a};
            lo_q      <= '1;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
          end else if (div_ovf) begin
            hi_q      <= '0;
            lo_q      <= {1'b1, {(W-1){1'b0}}};
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
          end else begin
            hi_q      <= '0;
            lo_q      <= is_div_in ? mag_a : mag_b;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
          end
        end
        MD_BUSY: if (bus.mm_start) begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod     = {hi_q[W-1:0], lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q[W-1:0] : hi_q[W-1:0];
    case (op_q)
      MD_MUL:                      result_sel = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_sel = prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:             result_sel = quo_fix;
      default:                     result_sel = rem_fix;
    endcase
  end

  assign bus.mm_done   = (state_q == MD_DONE);
  assign bus.mm_busy   = (state_q == MD_BUSY);
  assign bus.mm_result = (state_q == MD_DONE) ? result_sel : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic      clk;
  logic      rst;
  md_state_e dbg_state;
  int        n_cmp = 0;
  int        n_bad = 0;
  logic [31:0] exp_q[$];

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int          ai, bi;
    logic        ovf;
    ai  = a;
    bi  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(ai) * longint'(bi); return p[63:32]; end
      3'd2: begin p = longint'(ai) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ai / bi);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ai % bi);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // waits from a negedge for the done pulse; lat = number of rising edges taken (-1 on timeout)
  task automatic wait_done(input int budget, input bit scramble, output int lat,
                           output logic [31:0] res, output int busy_n);
    lat = -1; res = '0; busy_n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mm_busy) busy_n++;
      if (bus.mm_done) begin
        lat = k;
        res = bus.mm_result;
        break;
      end
      if (scramble) begin
        bus.mm_op = 3'($urandom_range(0, 7));
        bus.mm_a  = $urandom;
        bus.mm_b  = $urandom;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mm_done) pulses++;
    end
  endtask

  // driver: one full operation, start held until done; called at a negedge
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit scramble);
    int lat, busy_n, exp_lat;
    logic [31:0] res;
    exp_lat = ref_latency(op, a, b);
    exp_q.push_back(ref_result(op, a, b));
    bus.mm_start = 1'b1; bus.mm_op = op; bus.mm_a = a; bus.mm_b = b;
    wait_done(60, scramble, lat, res, busy_n);
    bus.mm_start = 1'b0;
    check_val({tag, "_res"}, res, exp_q.pop_front());
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_busy"}, 32'(busy_n), (exp_lat == 33) ? 32'd32 : 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_pulse"}, {31'b0, bus.mm_done}, 32'd0);
  endtask

  initial begin
    int lat, busy_n, pulses;
    logic [31:0] res;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst = 1'b1;
    bus.mm_start = 1'b0; bus.mm_op = '0; bus.mm_a = '0; bus.mm_b = '0;
    repeat (2) @(negedge clk);
    check_val("rst_done", {31'b0, bus.mm_done}, 32'd0);
    check_val("rst_busy", {31'b0, bus.mm_busy}, 32'd0);
    check_val("rst_result", bus.mm_result, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(MD_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_op("mul_7x6",   3'd0, 32'd7, 32'd6, 1'b0);
    run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0);
    run_op("divu_by0",  3'd5, 32'd5, 32'd0, 1'b0);
    run_op("rem_by0",   3'd6, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // back-to-back with start held across DONE
    bus.mm_start = 1'b1; bus.mm_op = 3'd0; bus.mm_a = 32'd3; bus.mm_b = 32'd4;
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd25);
    wait_done(60, 1'b0, lat, res, busy_n);
    check_val("b2b_first_res", res, exp_q.pop_front());
    check_val("b2b_first_lat", 32'(lat), 32'd33);
    bus.mm_a = 32'd5; bus.mm_b = 32'd5;
    wait_done(60, 1'b0, lat, res, busy_n);
    bus.mm_start = 1'b0;
    check_val("b2b_second_res", res, exp_q.pop_front());
    check_val("b2b_second_lat", 32'(lat), 32'd34);
    count_done(40, pulses);
    check_val("b2b_extra_pulses", 32'(pulses), 32'd0);

    // abort at BUSY cycle 10
    bus.mm_start = 1'b1; bus.mm_op = 3'd0; bus.mm_a = 32'd9; bus.mm_b = 32'd9;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.mm_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_state", 32'(dbg_state), 32'(MD_IDLE));
    check_val("abort_busy", {31'b0, bus.mm_busy}, 32'd0);
    check_val("abort_result", bus.mm_result, 32'd0);
    count_done(40, pulses);
    check_val("abort_pulses", 32'(pulses), 32'd0);

    // reset at BUSY cycle 20
    bus.mm_start = 1'b1; bus.mm_op = 3'd5; bus.mm_a = 32'd100; bus.mm_b = 32'd7;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_done", {31'b0, bus.mm_done}, 32'd0);
    check_val("midrst_busy", {31'b0, bus.mm_busy}, 32'd0);
    check_val("midrst_result", bus.mm_result, 32'd0);
    check_val("midrst_state", 32'(dbg_state), 32'(MD_IDLE));
    bus.mm_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_done(40, pulses);
    check_val("midrst_pulses", 32'(pulses), 32'd0);
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 1'b0);

    // randomized operations, inputs scrambled while busy
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
